// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/arb_grant.sv
// Picks fetch or data port among eligible requesters, bounding fetch starvation.
// Latency: combinational grant; burst counter updates at the end of each IDLE cycle.
// Backpressure: none here; requesters hold start until their done pulse.
module arb_grant
    import mem_arb_pkg::*;
#(
    parameter int MaxDataBurst = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic in_idle,
    input  logic if_start,
    input  logic if_served,
    input  logic d_start,
    input  logic d_served,
    output logic grant_valid,
    output logic grant_idx
);

    localparam int CntWidth = 4;
    localparam logic [CntWidth-1:0] BurstMax = CntWidth'(MaxDataBurst);

    logic [CntWidth-1:0] burst_cnt;
    logic                if_elig;
    logic                d_elig;

    assign if_elig     = if_start & ~if_served;
    assign d_elig      = d_start & ~d_served;
    assign grant_valid = if_elig | d_elig;
    // Data wins ties until it has used up its burst allowance against a waiting fetch.
    assign grant_idx   = (if_elig && (!d_elig || burst_cnt == BurstMax)) ? PORT_IF : PORT_D;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt <= '0;
        end else if (in_idle) begin
            if (!if_elig || grant_idx == PORT_IF) begin
                burst_cnt <= '0;
            end else if (burst_cnt != BurstMax) begin
                burst_cnt <= burst_cnt + CntWidth'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store requests onto the single memory start/done channel.
// Latency: done pulses 2 + N cycles after start is seen in IDLE (N = memory_done wait cycles).
// Backpressure: one request in flight; the other port waits with start held high.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AddrWidth    = 64,
    parameter int DataWidth    = 64,
    parameter int MaxDataBurst = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_start,
    input  logic [AddrWidth-1:0] if_addr,
    output logic                 if_done,
    output logic [DataWidth-1:0] if_data,
    input  logic                 d_start,
    input  logic                 d_sel_mem_operation,
    input  logic [1:0]           d_sel_mem_size,
    input  logic [AddrWidth-1:0] d_addr,
    input  logic [DataWidth-1:0] d_wdata,
    output logic                 d_done,
    output logic [DataWidth-1:0] d_data,
    output logic                 memory_start,
    output logic                 sel_mem_operation,
    output logic [1:0]           sel_mem_size,
    output logic [AddrWidth-1:0] addr,
    output logic [DataWidth-1:0] data_o,
    input  logic                 memory_done,
    input  logic [DataWidth-1:0] memory_value
);

    arb_state_t state_q, state_d;
    logic       gnt_q;
    logic       if_served_q, d_served_q;
    logic       grant_valid, grant_idx;
    logic       in_idle, take_grant, capture, responding;

    assign in_idle    = (state_q == IDLE);
    assign take_grant = in_idle && grant_valid;
    assign capture    = (state_q == ISSUE) && memory_done;
    assign responding = (state_q == RESPOND);

    arb_grant #(
        .MaxDataBurst (MaxDataBurst)
    ) u_arb_grant (
        .clk         (clk),
        .reset       (reset),
        .in_idle     (in_idle),
        .if_start    (if_start),
        .if_served   (if_served_q),
        .d_start     (d_start),
        .d_served    (d_served_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        memory_start = 1'b0;
        if_done      = 1'b0;
        d_done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) state_d = ISSUE;
            end
            ISSUE: begin
                memory_start = 1'b1;
                if (memory_done) state_d = RESPOND;
            end
            RESPOND: begin
                if_done = (gnt_q == PORT_IF);
                d_done  = (gnt_q == PORT_D);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Downstream fields are latched at grant so requester changes in flight are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q             <= PORT_IF;
            sel_mem_operation <= OP_READ;
            sel_mem_size      <= SIZE_B;
            addr              <= '0;
            data_o            <= '0;
        end else if (take_grant) begin
            gnt_q <= grant_idx;
            if (grant_idx == PORT_IF) begin
                sel_mem_operation <= OP_READ;
                sel_mem_size      <= SIZE_D;
                addr              <= if_addr;
                data_o            <= '0;
            end else begin
                sel_mem_operation <= d_sel_mem_operation;
                sel_mem_size      <= d_sel_mem_size;
                addr              <= d_addr;
                data_o            <= d_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_data <= '0;
            d_data  <= '0;
        end else if (capture) begin
            if (gnt_q == PORT_IF) if_data <= memory_value;
            else                  d_data  <= memory_value;
        end
    end

    // A served port stays ineligible until it withdraws its start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_served_q <= 1'b0;
            d_served_q  <= 1'b0;
        end else begin
            if (!if_start)                           if_served_q <= 1'b0;
            else if (responding && gnt_q == PORT_IF) if_served_q <= 1'b1;
            if (!d_start)                            d_served_q  <= 1'b0;
            else if (responding && gnt_q == PORT_D)  d_served_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences, randomized traffic.
module tb_mem_port_arbiter;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_start;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [DW-1:0] if_data;
    logic          d_start;
    logic          d_sel_mem_operation;
    logic [1:0]    d_sel_mem_size;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_data;
    logic          memory_start;
    logic          sel_mem_operation;
    logic [1:0]    sel_mem_size;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_o;
    logic          memory_done;
    logic [DW-1:0] memory_value;

    mem_port_arbiter #(
        .AddrWidth    (AW),
        .DataWidth    (DW),
        .MaxDataBurst (MAXB)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .if_start            (if_start),
        .if_addr             (if_addr),
        .if_done             (if_done),
        .if_data             (if_data),
        .d_start             (d_start),
        .d_sel_mem_operation (d_sel_mem_operation),
        .d_sel_mem_size      (d_sel_mem_size),
        .d_addr              (d_addr),
        .d_wdata             (d_wdata),
        .d_done              (d_done),
        .d_data              (d_data),
        .memory_start        (memory_start),
        .sel_mem_operation   (sel_mem_operation),
        .sel_mem_size        (sel_mem_size),
        .addr                (addr),
        .data_o              (data_o),
        .memory_done         (memory_done),
        .memory_value        (memory_value)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    typedef struct {
        logic        is_fetch;
        logic        op;
        logic [1:0]  size;
        logic [63:0] a;
        logic [63:0] wd;
        int          n_wait;
        logic [63:0] mval;
        int          exp_ms_cycles;
        logic        exp_op;
        logic [1:0]  exp_size;
        logic [63:0] exp_data_o;
        logic [63:0] exp_result;
    } vec_t;

    vec_t vecs[4];
    logic [63:0] hold_if_data;
    logic [63:0] hold_d_data;

    // One isolated transaction: issue, count memory_start cycles, answer, check the done side.
    task automatic run_vec(input vec_t v, input int idx);
        int   ms_cnt;
        logic got;
        ms_cnt = 0;
        got    = 1'b0;
        @(negedge clk);
        if (v.is_fetch) begin
            if_start = 1'b1;
            if_addr  = v.a;
            d_sel_mem_operation = v.op;
            d_sel_mem_size      = v.size;
        end else begin
            d_start             = 1'b1;
            d_sel_mem_operation = v.op;
            d_sel_mem_size      = v.size;
            d_addr              = v.a;
            d_wdata             = v.wd;
        end
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (memory_start) begin
                if (ms_cnt == 0) begin
                    chk($sformatf("v%0d_addr", idx), addr, v.a);
                    chk($sformatf("v%0d_op", idx), sel_mem_operation, v.exp_op);
                    chk($sformatf("v%0d_size", idx), sel_mem_size, v.exp_size);
                    chk($sformatf("v%0d_data_o", idx), data_o, v.exp_data_o);
                end
                ms_cnt++;
                memory_done  = (ms_cnt == v.n_wait + 1);
                memory_value = memory_done ? v.mval : rnd64();
            end else begin
                memory_done = 1'b0;
                if (ms_cnt > 0) begin
                    got = 1'b1;
                    chk($sformatf("v%0d_if_done", idx), if_done, v.is_fetch);
                    chk($sformatf("v%0d_d_done", idx), d_done, !v.is_fetch);
                    chk($sformatf("v%0d_result", idx), v.is_fetch ? if_data : d_data, v.exp_result);
                end
            end
        end
        chk($sformatf("v%0d_done_seen", idx), got, 1'b1);
        chk($sformatf("v%0d_ms_cycles", idx), ms_cnt, v.exp_ms_cycles);
        // start still held: no second pulse, no re-issue
        @(negedge clk);
        chk($sformatf("v%0d_no_reissue", idx), memory_start, 1'b0);
        chk($sformatf("v%0d_single_pulse", idx), if_done | d_done, 1'b0);
        if (v.is_fetch) begin
            if_start     = 1'b0;
            hold_if_data = v.exp_result;
        end else begin
            d_start     = 1'b0;
            hold_d_data = v.exp_result;
        end
        @(negedge clk);
        chk($sformatf("v%0d_stay_idle", idx), memory_start, 1'b0);
    endtask

    // Random-phase state
    logic        pend_if, pend_d, prev_ms, prev_idle, prev_pif, prev_pd;
    logic        infl, resp_due, exp_port, ms;
    logic [63:0] resp_val, g_addr, g_data_o, e_addr, e_data_o;
    logic        e_op;
    logic [1:0]  e_size;
    int          gap_if, gap_d, cnt_m, wait_m, gcount;
    logic        prev_s;
    logic [63:0] exp_a;

    initial begin
        reset = 1'b0;
        if_start = 1'b0; if_addr = '0;
        d_start = 1'b0; d_sel_mem_operation = 1'b0; d_sel_mem_size = 2'b00;
        d_addr = '0; d_wdata = '0;
        memory_done = 1'b0; memory_value = '0;
        hold_if_data = '0; hold_d_data = '0;

        vecs[0] = '{1'b1, 1'b0, 2'b00, 64'h100, 64'h0, 3, 64'h13,
                    4, 1'b0, 2'b11, 64'h0, 64'h13};
        vecs[1] = '{1'b0, 1'b1, 2'b10, 64'h200, 64'hDEADBEEF, 1, 64'h0,
                    2, 1'b1, 2'b10, 64'hDEADBEEF, 64'h0};
        vecs[2] = '{1'b0, 1'b0, 2'b00, 64'h3F1, 64'h1111, 0, 64'hA5,
                    1, 1'b0, 2'b00, 64'h1111, 64'hA5};
        vecs[3] = '{1'b1, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 2, 64'h0123_4567_89AB_CDEF,
                    3, 1'b0, 2'b11, 64'h0, 64'h0123_4567_89AB_CDEF};

        #2;
        chk("rst_memory_start", memory_start, 1'b0);
        chk("rst_if_done", if_done, 1'b0);
        chk("rst_d_done", d_done, 1'b0);
        chk("rst_if_data", if_data, 64'h0);
        chk("rst_d_data", d_data, 64'h0);
        chk("rst_addr", addr, 64'h0);
        chk("rst_data_o", data_o, 64'h0);
        chk("rst_op_size", {sel_mem_operation, sel_mem_size}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Reset while a fetch is in ISSUE
        @(negedge clk);
        if_start = 1'b1; if_addr = 64'h500;
        @(negedge clk);
        chk("rstmid_pre_ms", memory_start, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_ms", memory_start, 1'b0);
        chk("rstmid_done", {if_done, d_done}, 2'b00);
        chk("rstmid_if_data", if_data, 64'h0);
        chk("rstmid_d_data", d_data, 64'h0);
        if_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        hold_d_data = '0;
        run_vec(vecs[0], 4);

        // Stray memory_done while idle
        @(negedge clk);
        memory_done = 1'b1; memory_value = 64'hBAD;
        @(negedge clk);
        memory_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_ms", memory_start, 1'b0);
            chk("stray_done", {if_done, d_done}, 2'b00);
            chk("stray_if_data", if_data, hold_if_data);
            chk("stray_d_data", d_data, hold_d_data);
        end

        // Simultaneous requests: data first, then fetch straight after
        @(negedge clk);
        if_start = 1'b1; if_addr = 64'h700;
        d_start = 1'b1; d_sel_mem_operation = 1'b0; d_sel_mem_size = 2'b01;
        d_addr = 64'h800; d_wdata = 64'h55;
        @(negedge clk);
        chk("sim_first_ms", memory_start, 1'b1);
        chk("sim_first_addr", addr, 64'h800);
        memory_done = 1'b1; memory_value = 64'h66;
        @(negedge clk);
        memory_done = 1'b0;
        chk("sim_d_done", {if_done, d_done}, 2'b01);
        chk("sim_d_data", d_data, 64'h66);
        d_start = 1'b0;
        @(negedge clk);
        chk("sim_idle_gap", memory_start, 1'b0);
        @(negedge clk);
        chk("sim_second_ms", memory_start, 1'b1);
        chk("sim_second_addr", addr, 64'h700);
        chk("sim_second_size", sel_mem_size, 2'b11);
        memory_done = 1'b1; memory_value = 64'h77;
        @(negedge clk);
        memory_done = 1'b0;
        chk("sim_if_done", {if_done, d_done}, 2'b10);
        chk("sim_if_data", if_data, 64'h77);
        if_start = 1'b0;
        @(negedge clk);

        // Starvation bound: two rounds of MAXB data grants followed by one fetch grant
        if_start = 1'b1; if_addr = 64'hA00;
        d_start = 1'b1; d_addr = 64'hB00; d_sel_mem_operation = 1'b0; d_sel_mem_size = 2'b11;
        gcount = 0; prev_s = 1'b0;
        for (int k = 0; k < 200 && gcount < 2 * (MAXB + 1); k++) begin
            @(negedge clk);
            memory_done = 1'b0;
            if (memory_start && !prev_s) begin
                exp_a = ((gcount % (MAXB + 1)) == MAXB) ? 64'hA00 : 64'hB00;
                chk($sformatf("starve_g%0d", gcount), addr, exp_a);
                gcount++;
                memory_done = 1'b1;
                memory_value = rnd64();
            end
            if (d_done)         d_start = 1'b0;
            else if (!d_start)  d_start = 1'b1;
            if (if_done)        if_start = 1'b0;
            else if (!if_start) if_start = 1'b1;
            prev_s = memory_start;
        end
        chk("starve_grants", gcount, 2 * (MAXB + 1));
        @(negedge clk);
        memory_done = 1'b0; if_start = 1'b0; d_start = 1'b0;
        repeat (3) @(negedge clk);

        // Randomized traffic against a transaction-level model
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        pend_if = 1'b0; pend_d = 1'b0; gap_if = 0; gap_d = 0;
        prev_ms = 1'b0; prev_idle = 1'b1; prev_pif = 1'b0; prev_pd = 1'b0;
        cnt_m = 0; wait_m = 0; infl = 1'b0; resp_due = 1'b0; resp_val = '0;
        g_addr = '0; g_data_o = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            ms = memory_start;
            if (prev_idle && (prev_pif || prev_pd)) chk("rnd_idle_grant", ms, 1'b1);
            if (ms && !prev_ms) begin
                exp_port = (prev_pif && (!prev_pd || cnt_m == MAXB)) ? 1'b0 : 1'b1;
                if (exp_port == 1'b0 || !prev_pif) cnt_m = 0;
                else if (cnt_m < MAXB)             cnt_m = cnt_m + 1;
                if (exp_port == 1'b0) begin
                    e_addr = if_addr; e_op = 1'b0; e_size = 2'b11; e_data_o = '0;
                end else begin
                    e_addr = d_addr; e_op = d_sel_mem_operation; e_size = d_sel_mem_size; e_data_o = d_wdata;
                end
                chk("rnd_addr", addr, e_addr);
                chk("rnd_op", sel_mem_operation, e_op);
                chk("rnd_size", sel_mem_size, e_size);
                chk("rnd_data_o", data_o, e_data_o);
                g_addr = e_addr; g_data_o = e_data_o;
                infl = exp_port;
                wait_m = $urandom_range(0, 3);
            end else if (ms) begin
                chk("rnd_hold_addr", addr, g_addr);
                chk("rnd_hold_data_o", data_o, g_data_o);
            end
            chk("rnd_if_done", if_done, resp_due && infl == 1'b0);
            chk("rnd_d_done", d_done, resp_due && infl == 1'b1);
            if (resp_due) chk("rnd_result", (infl == 1'b0) ? if_data : d_data, resp_val);
            resp_due = 1'b0;

            if (ms) begin
                memory_value = rnd64();
                if (wait_m == 0) begin
                    memory_done = 1'b1;
                    resp_due = 1'b1;
                    resp_val = memory_value;
                end else begin
                    wait_m--;
                    memory_done = 1'b0;
                end
                if ($urandom_range(0, 1) == 1) begin
                    if (infl == 1'b0) if_addr = rnd64();
                    else begin d_addr = rnd64(); d_wdata = rnd64(); d_sel_mem_size = 2'($urandom_range(0, 3)); end
                end
            end else begin
                memory_done = ($urandom_range(0, 7) == 0);
                memory_value = rnd64();
            end

            if (pend_if && if_done) begin
                if_start = 1'b0; pend_if = 1'b0; gap_if = $urandom_range(0, 3);
            end else if (!pend_if) begin
                if (gap_if > 0) gap_if--;
                else if ($urandom_range(0, 2) != 0) begin
                    if_start = 1'b1; if_addr = rnd64(); pend_if = 1'b1;
                end
            end
            if (pend_d && d_done) begin
                d_start = 1'b0; pend_d = 1'b0; gap_d = $urandom_range(0, 3);
            end else if (!pend_d) begin
                if (gap_d > 0) gap_d--;
                else if ($urandom_range(0, 2) != 0) begin
                    d_start = 1'b1; d_addr = rnd64(); d_wdata = rnd64();
                    d_sel_mem_operation = 1'($urandom_range(0, 1));
                    d_sel_mem_size = 2'($urandom_range(0, 3));
                    pend_d = 1'b1;
                end
            end
            prev_pif  = pend_if;
            prev_pd   = pend_d;
            prev_ms   = ms;
            prev_idle = !ms && !if_done && !d_done;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
